// File: rtl/parity_frame_tx.sv
// UART-style frame transmitter: start, DW data bits LSB-first, parity, stop.
// Optional input-parity checker enabled by defining PARITY_FRAME_TX_CHECK_EN.
module parity_frame_tx #(
    parameter int unsigned DW           = 4,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_in,
    input  logic          par_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          tx_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          par_err_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BW = $clog2(DW + 1);
    localparam logic [CW-1:0] CntMax = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BitMax = BW'(DW - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          boundary;

`ifdef PARITY_FRAME_TX_CHECK_EN
    logic par_err_q, par_err_d;
`endif

    assign boundary = (cnt_q == CntMax);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef PARITY_FRAME_TX_CHECK_EN
        par_err_d = par_err_q;
`endif
        if (state_q != StIdle) begin
            cnt_d = boundary ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StStart;
                    shreg_d = data_in;
                    par_d   = par_in;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    bit_d   = '0;
`ifdef PARITY_FRAME_TX_CHECK_EN
                    par_err_d = ((~^data_in) != par_in);
`endif
                end
            end
            StStart: begin
                if (boundary) begin
                    state_d = StData;
                    tx_d    = shreg_q[0];
                end
            end
            StData: begin
                if (boundary) begin
                    if (bit_q == BitMax) begin
                        state_d = StParity;
                        tx_d    = par_q;
                    end else begin
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shreg_d[0];
                    end
                end
            end
            StParity: begin
                if (boundary) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (boundary) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef PARITY_FRAME_TX_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
    assign par_err_o = par_err_q;
`else
    assign par_err_o = 1'b0;
`endif

    // Gated by rst so no word is offered while the block is held in reset.
    assign in_ready = (state_q == StIdle) && !rst;
    assign tx_o     = tx_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: one DUT at CLKS_PER_BIT=4, one at CLKS_PER_BIT=1.
module tb_parity_frame_tx;

    logic       clk = 1'b0;
    logic       rst, par_in, in_valid, in_ready, tx, busy, done, perr;
    logic [3:0] data_in;
    logic       rst_b, p_b, v_b, rdy_b, tx_b, busy_b, done_b, perr_b;
    logic [3:0] d_b;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    parity_frame_tx #(.DW(4), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_in), .par_in(par_in), .in_valid(in_valid),
        .in_ready(in_ready), .tx_o(tx), .busy_o(busy), .done_o(done), .par_err_o(perr)
    );

    parity_frame_tx #(.DW(4), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .rst(rst_b), .data_in(d_b), .par_in(p_b), .in_valid(v_b),
        .in_ready(rdy_b), .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b), .par_err_o(perr_b)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // bits[0] is the start bit, bits[6] the stop bit; 4 cycles per bit.
    task automatic frame_a(input logic [3:0] d, input logic p, input logic [6:0] bits,
                           input logic pe, input bit pre, input bit poke);
        if (!pre) begin
            @(negedge clk);
            data_in  = d;
            par_in   = p;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("par_err_accept", perr, pe);
        for (int c = 0; c < 28; c++) begin
            chk($sformatf("tx c%0d", c), tx, bits[c/4]);
            chk($sformatf("busy c%0d", c), busy, 1'b1);
            chk($sformatf("done c%0d", c), done, 1'b0);
            chk($sformatf("rdy c%0d", c), in_ready, 1'b0);
            if (poke && c == 6) begin
                in_valid = 1'b1;
                data_in  = 4'b0101;
                par_in   = 1'b1;
            end
            @(negedge clk);
        end
        chk("end_tx", tx, 1'b1);
        chk("end_busy", busy, 1'b0);
        chk("end_done", done, 1'b1);
        chk("end_rdy", in_ready, 1'b1);
        chk("end_par_err", perr, pe);
    endtask

    initial begin
        logic exp_b [15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                             1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        rst = 1'b1; rst_b = 1'b1;
        data_in = 4'd0; par_in = 1'b0; in_valid = 1'b0;
        d_b = 4'd0; p_b = 1'b0; v_b = 1'b0;
        #2;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rdy", in_ready, 1'b0);
        chk("rst_par_err", perr, 1'b0);
        chk("rst_b_tx", tx_b, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        chk("idle_rdy", in_ready, 1'b1);
        chk("idle_tx", tx, 1'b1);

        // Basic frame 1011, parity 0
        frame_a(4'b1011, 1'b0, 7'b1010110, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("done_once", done, 1'b0);
        chk("rdy_after", in_ready, 1'b1);

        // All-zero data, parity 1
        frame_a(4'b0000, 1'b1, 7'b1100000, 1'b0, 1'b0, 1'b0);

        // Busy ignore: 0101 offered mid-frame, accepted only once idle again
        frame_a(4'b1011, 1'b0, 7'b1010110, 1'b0, 1'b0, 1'b1);
        frame_a(4'b0101, 1'b1, 7'b1101010, 1'b0, 1'b1, 1'b0);

        // Reset at cycle 10 of a frame
        @(negedge clk);
        data_in = 4'b0000; par_in = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_tx", tx, 1'b0);
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_rdy", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", in_ready, 1'b1);
        chk("post_rst_done", done, 1'b0);
        chk("post_rst_tx", tx, 1'b1);
        frame_a(4'b1011, 1'b0, 7'b1010110, 1'b0, 1'b0, 1'b0);

`ifdef PARITY_FRAME_TX_CHECK_EN
        frame_a(4'b1011, 1'b1, 7'b1110110, 1'b1, 1'b0, 1'b0);
        frame_a(4'b0000, 1'b1, 7'b1100000, 1'b0, 1'b0, 1'b0);
`endif

        // Back-to-back at CLKS_PER_BIT=1 with in_valid held
        @(negedge clk);
        d_b = 4'b0110; p_b = 1'b1; v_b = 1'b1;
        @(negedge clk);
        d_b = 4'b1111; p_b = 1'b1;
        for (int c = 0; c < 15; c++) begin
            chk($sformatf("b tx c%0d", c), tx_b, exp_b[c]);
            chk($sformatf("b busy c%0d", c), busy_b, (c != 7));
            chk($sformatf("b done c%0d", c), done_b, (c == 7));
            chk($sformatf("b rdy c%0d", c), rdy_b, (c == 7));
            if (c == 8) v_b = 1'b0;
            @(negedge clk);
        end
        chk("b_end_done", done_b, 1'b1);
        chk("b_end_busy", busy_b, 1'b0);
        chk("b_end_rdy", rdy_b, 1'b1);
        chk("b_end_tx", tx_b, 1'b1);
        chk("b_par_err", perr_b, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
